// File: rtl/log_unit_pipe.sv
// log_unit_pipe: 3-stage valid/ready logical execution unit.
// Bitwise ops, sign extension, clz, byte popcount and CR0 on XLEN operands.
module log_unit_pipe #(
  parameter int RS_ID_WIDTH = 5,
  parameter int XLEN        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [RS_ID_WIDTH-1:0] rs_id_in,
  input  logic [4:0]             result_reg_addr_in,
  input  logic [XLEN-1:0]        op1,
  input  logic [XLEN-1:0]        op2,
  input  logic [3:0]             op,
  input  logic                   alter_cr0,
  input  logic                   xer_so,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [RS_ID_WIDTH-1:0] rs_id_out,
  output logic [4:0]             result_reg_addr_out,
  output logic [XLEN-1:0]        result,
  output logic [3:0]             cr0,
  output logic                   cr0_valid,
  output logic                   xer_valid
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("log_unit_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic                   v;
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]             addr;
    logic [XLEN-1:0]        a;
    logic [XLEN-1:0]        b;
    logic [3:0]             op;
    logic                   alt;
    logic                   so;
  } s0_t;

  typedef struct packed {
    logic                   v;
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]             addr;
    logic [XLEN-1:0]        res;
    logic                   alt;
    logic                   so;
  } s1_t;

  typedef struct packed {
    logic                   v;
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]             addr;
    logic [XLEN-1:0]        res;
    logic [3:0]             cr0;
    logic                   alt;
  } s2_t;

  s0_t s0_q, s0_d;
  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  logic en0, en1, en2;
  logic [XLEN-1:0] res_c;
  logic [3:0] cr0_c;

  // Low w bits kept, bit w-1 replicated upward (w == XLEN is a pass-through).
  function automatic logic [XLEN-1:0] sext(
    input logic [XLEN-1:0] a,
    input int w
  );
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++)
      r[i] = (i < w) ? a[i] : a[w-1];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] clz(
    input logic [XLEN-1:0] a,
    input int w
  );
    logic [6:0] n;
    logic hit;
    n   = '0;
    hit = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (i < w) begin
        if (a[i]) hit = 1'b1;
        else if (!hit) n = n + 7'd1;
      end
    end
    return {{(XLEN-7){1'b0}}, n};
  endfunction

  function automatic logic [XLEN-1:0] popcntb(
    input logic [XLEN-1:0] a
  );
    logic [XLEN-1:0] r;
    logic [3:0] c;
    r = '0;
    for (int b = 0; b < XLEN / 8; b++) begin
      c = '0;
      for (int k = 0; k < 8; k++)
        c = c + {3'b000, a[8*b+k]};
      r[8*b +: 8] = {4'b0000, c};
    end
    return r;
  endfunction

  always_comb begin
    res_c = '0;
    case (s0_q.op)
      4'd0:  res_c = s0_q.a & s0_q.b;
      4'd1:  res_c = s0_q.a | s0_q.b;
      4'd2:  res_c = s0_q.a ^ s0_q.b;
      4'd3:  res_c = ~(s0_q.a & s0_q.b);
      4'd4:  res_c = ~(s0_q.a | s0_q.b);
      4'd5:  res_c = ~(s0_q.a ^ s0_q.b);
      4'd6:  res_c = s0_q.a & ~s0_q.b;
      4'd7:  res_c = s0_q.a | ~s0_q.b;
      4'd8:  res_c = sext(s0_q.a, 8);
      4'd9:  res_c = sext(s0_q.a, 16);
      4'd10: res_c = sext(s0_q.a, 32);
      4'd11: res_c = clz(s0_q.a, 32);
      4'd12: res_c = clz(s0_q.a, XLEN);
      4'd13: res_c = popcntb(s0_q.a);
      default: res_c = '0;
    endcase
  end

  always_comb begin
    cr0_c[3] = s1_q.res[XLEN-1];
    cr0_c[1] = (s1_q.res == '0);
    cr0_c[2] = ~cr0_c[3] & ~cr0_c[1];
    cr0_c[0] = s1_q.so;
  end

  // Each stage advances when empty or when its downstream moves.
  always_comb begin
    en2 = ~s2_q.v | output_ready;
    en1 = ~s1_q.v | en2;
    en0 = ~s0_q.v | en1;
  end

  always_comb begin
    s0_d = s0_q;
    if (en0) begin
      s0_d.v = input_valid;
      if (input_valid) begin
        s0_d.rs_id = rs_id_in;
        s0_d.addr  = result_reg_addr_in;
        s0_d.a     = op1;
        s0_d.b     = op2;
        s0_d.op    = op;
        s0_d.alt   = alter_cr0;
        s0_d.so    = xer_so;
      end
    end
  end

  always_comb begin
    s1_d = s1_q;
    if (en1) begin
      s1_d.v = s0_q.v;
      if (s0_q.v) begin
        s1_d.rs_id = s0_q.rs_id;
        s1_d.addr  = s0_q.addr;
        s1_d.res   = res_c;
        s1_d.alt   = s0_q.alt;
        s1_d.so    = s0_q.so;
      end
    end
  end

  always_comb begin
    s2_d = s2_q;
    if (en2) begin
      s2_d.v = s1_q.v;
      if (s1_q.v) begin
        s2_d.rs_id = s1_q.rs_id;
        s2_d.addr  = s1_q.addr;
        s2_d.res   = s1_q.res;
        s2_d.cr0   = cr0_c;
        s2_d.alt   = s1_q.alt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign input_ready         = en0;
  assign output_valid        = s2_q.v;
  assign rs_id_out           = s2_q.rs_id;
  assign result_reg_addr_out = s2_q.addr;
  assign result              = s2_q.res;
  assign cr0                 = s2_q.cr0;
  assign cr0_valid           = s2_q.alt;
  assign xer_valid           = 1'b0;

endmodule

// File: tb/tb_log_unit_pipe.sv
// tb_log_unit_pipe: directed checks of log_unit_pipe at XLEN=32 and 64.
// Both instances share handshakes; the 32-bit one sees the low operand word.
module tb_log_unit_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic input_valid = 1'b0;
  logic output_ready = 1'b0;
  logic alter_cr0 = 1'b0;
  logic xer_so = 1'b0;
  logic [4:0] rs_id_in = '0;
  logic [4:0] addr_in = '0;
  logic [63:0] op1 = '0;
  logic [63:0] op2 = '0;
  logic [3:0] op = '0;

  logic ir32, ov32, cv32, xv32;
  logic [4:0] rs32, ad32;
  logic [31:0] res32;
  logic [3:0] cr32;
  logic ir64, ov64, cv64, xv64;
  logic [4:0] rs64, ad64;
  logic [63:0] res64;
  logic [3:0] cr64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  log_unit_pipe #(.RS_ID_WIDTH(5), .XLEN(32)) u32 (
    .clk(clk), .rst(rst),
    .input_valid(input_valid), .input_ready(ir32),
    .rs_id_in(rs_id_in), .result_reg_addr_in(addr_in),
    .op1(op1[31:0]), .op2(op2[31:0]), .op(op),
    .alter_cr0(alter_cr0), .xer_so(xer_so),
    .output_valid(ov32), .output_ready(output_ready),
    .rs_id_out(rs32), .result_reg_addr_out(ad32),
    .result(res32), .cr0(cr32),
    .cr0_valid(cv32), .xer_valid(xv32)
  );

  log_unit_pipe #(.RS_ID_WIDTH(5), .XLEN(64)) u64 (
    .clk(clk), .rst(rst),
    .input_valid(input_valid), .input_ready(ir64),
    .rs_id_in(rs_id_in), .result_reg_addr_in(addr_in),
    .op1(op1), .op2(op2), .op(op),
    .alter_cr0(alter_cr0), .xer_so(xer_so),
    .output_valid(ov64), .output_ready(output_ready),
    .rs_id_out(rs64), .result_reg_addr_out(ad64),
    .result(res64), .cr0(cr64),
    .cr0_valid(cv64), .xer_valid(xv64)
  );

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        alt;
    logic        so;
    logic [63:0] r32;
    logic [3:0]  c32;
    logic [63:0] r64;
    logic [3:0]  c64;
  } vec_t;

  vec_t vt[17];
  logic [4:0]  q_rs[$];
  logic [63:0] q_res[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input int i);
    int n;
    op           = vt[i].op;
    op1          = vt[i].a;
    op2          = vt[i].b;
    alter_cr0    = vt[i].alt;
    xer_so       = vt[i].so;
    rs_id_in     = 5'(i + 1);
    addr_in      = 5'(31 - i);
    input_valid  = 1'b1;
    output_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_rdy", i), 64'(ir64), 64'd1);
    tick();
    input_valid = 1'b0;
    n = 1;
    while (!ov64 && n < 8) begin
      tick();
      n++;
    end
    chk($sformatf("v%0d_lat", i), 64'(n), 64'd3);
    chk($sformatf("v%0d_ov32", i), 64'(ov32), 64'd1);
    chk($sformatf("v%0d_res32", i), 64'(res32), vt[i].r32);
    chk($sformatf("v%0d_cr32", i), 64'(cr32), 64'(vt[i].c32));
    chk($sformatf("v%0d_res64", i), res64, vt[i].r64);
    chk($sformatf("v%0d_cr64", i), 64'(cr64), 64'(vt[i].c64));
    chk($sformatf("v%0d_crv", i), 64'(cv64), 64'(vt[i].alt));
    chk($sformatf("v%0d_rs", i), 64'(rs64), 64'(i + 1));
    chk($sformatf("v%0d_addr", i), 64'(ad64), 64'(31 - i));
    chk($sformatf("v%0d_xer", i), 64'({xv32, xv64}), 64'd0);
    tick();
  endtask

  task automatic stream(input int n, input int st, input int sl,
                        input int base);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int first_acc = -1;
    int first_out = -1;
    int last_out = -1;
    logic pstall = 1'b0;
    logic [4:0] prs = '0;
    logic [63:0] pres = '0;
    logic [63:0] v;
    while (got < n && cyc < 200) begin
      output_ready = !(cyc >= st && cyc < st + sl);
      input_valid  = (sent < n);
      rs_id_in     = 5'(base + sent);
      addr_in      = 5'(sent);
      op           = 4'd1;
      op1          = 64'(32'h0000_1000 + base * 256 + sent);
      op2          = '0;
      alter_cr0    = 1'b0;
      xer_so       = 1'b0;
      #1;
      if (pstall) begin
        chk("hold_rs", 64'(rs64), 64'(prs));
        chk("hold_res", res64, pres);
      end
      pstall = ov64 && !output_ready;
      prs    = rs64;
      pres   = res64;
      if (sl > 0 && cyc == st + sl - 1) begin
        chk("full_rdy", 64'(ir64), 64'd0);
        chk("full_cnt", 64'(q_rs.size()), 64'd3);
      end
      if (ov64 && output_ready) begin
        if (q_rs.size() == 0) begin
          chk("spurious_out", 64'(ov64), 64'd0);
        end else begin
          chk("ord_rs", 64'(rs64), 64'(q_rs.pop_front()));
          v = q_res.pop_front();
          chk("ord_res64", res64, v);
          chk("ord_res32", 64'(res32), v);
        end
        got++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (input_valid && ir64) begin
        q_rs.push_back(rs_id_in);
        q_res.push_back(op1);
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      tick();
      cyc++;
    end
    input_valid = 1'b0;
    chk("drain", 64'(got), 64'(n));
    if (sl == 0) begin
      chk("b2b_lat", 64'(first_out - first_acc), 64'd3);
      chk("b2b_rate", 64'(last_out - first_out), 64'(n - 1));
    end
  endtask

  initial begin
    vt[0]  = '{4'd0, 64'hF0F0_1234, 64'h0FF0_FFFF, 1'b1, 1'b1,
               64'h00F0_1234, 4'b0101, 64'h00F0_1234, 4'b0101};
    vt[1]  = '{4'd8, 64'h80, 64'h0, 1'b1, 1'b0,
               64'hFFFF_FF80, 4'b1000, 64'hFFFF_FFFF_FFFF_FF80, 4'b1000};
    vt[2]  = '{4'd9, 64'h7FFF, 64'h0, 1'b1, 1'b0,
               64'h7FFF, 4'b0100, 64'h7FFF, 4'b0100};
    vt[3]  = '{4'd12, 64'h0, 64'h0, 1'b1, 1'b0,
               64'd32, 4'b0100, 64'd64, 4'b0100};
    vt[4]  = '{4'd11, 64'hFFFF_FFFF_0000_0001, 64'h0, 1'b1, 1'b0,
               64'd31, 4'b0100, 64'd31, 4'b0100};
    vt[5]  = '{4'd13, 64'hFF01_0300_0000_0007, 64'h0, 1'b1, 1'b0,
               64'h3, 4'b0100, 64'h0801_0200_0000_0003, 4'b0100};
    vt[6]  = '{4'd10, 64'h8000_0000, 64'h0, 1'b1, 1'b0,
               64'h8000_0000, 4'b1000, 64'hFFFF_FFFF_8000_0000, 4'b1000};
    vt[7]  = '{4'd4, 64'h0, 64'h0, 1'b1, 1'b1,
               64'hFFFF_FFFF, 4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1001};
    vt[8]  = '{4'd6, 64'hFF00, 64'h0F00, 1'b0, 1'b0,
               64'hF000, 4'b0100, 64'hF000, 4'b0100};
    vt[9]  = '{4'd5, 64'h1234, 64'h1234, 1'b1, 1'b0,
               64'hFFFF_FFFF, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
    vt[10] = '{4'd2, 64'hAB, 64'hAB, 1'b1, 1'b1,
               64'h0, 4'b0011, 64'h0, 4'b0011};
    vt[11] = '{4'd7, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
               64'h0, 4'b0010, 64'h0, 4'b0010};
    vt[12] = '{4'd1, 64'h1_0000_0000, 64'h5, 1'b1, 1'b0,
               64'h5, 4'b0100, 64'h1_0000_0005, 4'b0100};
    vt[13] = '{4'd12, 64'h0010_0000, 64'h0, 1'b1, 1'b0,
               64'd11, 4'b0100, 64'd43, 4'b0100};
    vt[14] = '{4'd3, 64'hFFFF_FFFF_0000_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b1, 1'b0,
               64'hFFFF_0000, 4'b1000, 64'h0000_0000_FFFF_0000, 4'b0100};
    vt[15] = '{4'd15, 64'h1234, 64'h5678, 1'b1, 1'b1,
               64'h0, 4'b0011, 64'h0, 4'b0011};
    vt[16] = '{4'd14, 64'hFFFF, 64'hFFFF, 1'b0, 1'b0,
               64'h0, 4'b0010, 64'h0, 4'b0010};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_ov", 64'({ov32, ov64}), 64'd0);
    chk("rst_res", res64 | 64'(res32), 64'd0);
    chk("rst_cr0", 64'({cr32, cr64}), 64'd0);
    chk("rst_crv", 64'({cv32, cv64}), 64'd0);
    chk("rst_tag", 64'({rs32, ad32, rs64, ad64}), 64'd0);
    chk("rst_xer", 64'({xv32, xv64}), 64'd0);
    chk("rst_rdy", 64'({ir32, ir64}), 64'd3);
    tick();

    for (int i = 0; i < 15; i++) send_vec(i);
    send_vec(16);

    stream(8, 1000, 0, 1);
    stream(8, 2, 10, 9);

    output_ready = 1'b0;
    input_valid  = 1'b1;
    op           = 4'd0;
    op1          = 64'hFFFF;
    op2          = 64'hFFFF;
    for (int k = 0; k < 3; k++) begin
      rs_id_in = 5'(20 + k);
      tick();
    end
    chk("pre_rst_full", 64'(ir64), 64'd0);
    chk("pre_rst_ov", 64'(ov64), 64'd1);
    input_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    output_ready = 1'b1;
    chk("mid_rst_ov", 64'({ov32, ov64}), 64'd0);
    chk("mid_rst_rdy", 64'(ir64), 64'd1);
    chk("mid_rst_rs", 64'(rs64), 64'd0);
    for (int k = 0; k < 5; k++) begin
      chk("no_stale", 64'(ov64), 64'd0);
      tick();
    end
    send_vec(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
